core_arf_scoreboard: RTL

//  Register scoreboard for the 16x16 architectural register file. Tracks in-flight writes per register,

---
 rtl/core_arf_scoreboard_pkg.sv | 21 ++
 rtl/core_arf_sb_cnt.sv | 33 +++
 rtl/core_arf_scoreboard.sv | 116 +++++++++++
 3 files changed

// File: rtl/core_arf_scoreboard_pkg.sv
// Shared constants and types for the architectural register file scoreboard.
// The ARF has 16 registers and R0 reads as zero.
package core_pkg;

    localparam int REG_AW       = 4;
    localparam int NREG         = 16;
    localparam int SSC_EX       = 1;
    localparam int SSC_MEM      = 1;
    localparam int WB_PORTS_DEF = SSC_EX + SSC_MEM;

    typedef logic [REG_AW-1:0] reg_idx_t;

    // One-hot decode of a register index.
    function automatic logic [NREG-1:0] reg_onehot(input reg_idx_t r);
        logic [NREG-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/core_arf_sb_cnt.sv
// Per-register in-flight write counter: up on issue, down on writeback,
// cleared on flush, flags a writeback that arrives with nothing pending.
module core_arf_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] cnt_reg;

    assign cnt_o       = cnt_reg;
    assign underflow_o = dec_i & ~inc_i & ~clr_i & (cnt_reg == '0);

    // Simultaneous inc and dec cancel; the issue gate keeps inc away from a full counter.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_reg <= '0;
        end else if (clr_i) begin
            cnt_reg <= '0;
        end else if (inc_i && !dec_i) begin
            cnt_reg <= cnt_reg + 1'b1;
        end else if (dec_i && !inc_i && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

endmodule

// File: rtl/core_arf_scoreboard.sv
// Register scoreboard: tracks pending writes per ARF register, gates issue on
// RAW hazards and full counters, and retires pending writes from the writeback ports.
module core_arf_scoreboard
    import core_pkg::*;
#(
    parameter int WB_PORTS  = WB_PORTS_DEF,
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       flush_i,
    input  logic                       iss_valid_i,
    output logic                       iss_ready_o,
    input  logic                       iss_rd_en_i,
    input  logic [REG_AW-1:0]          iss_rd_i,
    input  logic [1:0]                 iss_rs_en_i,
    input  logic [REG_AW-1:0]          iss_rs_a_i,
    input  logic [REG_AW-1:0]          iss_rs_b_i,
    input  logic [WB_PORTS-1:0]        wb_en_i,
    input  logic [WB_PORTS*REG_AW-1:0] wb_addr_i,
    output logic [NREG-1:0]            busy_o,
    output logic [15:0]                stall_cnt_o,
    output logic                       err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NREG-1:0][CNT_W-1:0] cnt_q;
    logic [NREG-1:0]            wb_hit;
    logic [NREG-1:0]            busy_eff;
    logic [NREG-1:0]            inc_vec;
    logic [NREG-1:0]            underflow;
    logic                       wb_dup;
    logic                       raw;
    logic                       full;
    logic                       fire;
    logic [15:0]                stall_cnt_reg;
    logic                       err_reg;

    // Writeback decode; two ports hitting the same live register is a protocol error.
    always_comb begin
        reg_idx_t addr_p;
        reg_idx_t addr_q;
        wb_hit = '0;
        wb_dup = 1'b0;
        addr_p = '0;
        addr_q = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            addr_p = wb_addr_i[p*REG_AW +: REG_AW];
            if (wb_en_i[p]) begin
                wb_hit = wb_hit | reg_onehot(addr_p);
            end
            for (int q = p + 1; q < WB_PORTS; q++) begin
                addr_q = wb_addr_i[q*REG_AW +: REG_AW];
                if (wb_en_i[p] && wb_en_i[q] && (addr_p == addr_q) && (addr_p != '0)) begin
                    wb_dup = 1'b1;
                end
            end
        end
        wb_hit[0] = 1'b0;
    end

    assign cnt_q[0]     = '0;
    assign underflow[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
            core_arf_sb_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk_i       (clk_i),
                .arst_ni     (arst_ni),
                .clr_i       (flush_i),
                .inc_i       (inc_vec[gi]),
                .dec_i       (wb_hit[gi]),
                .cnt_o       (cnt_q[gi]),
                .underflow_o (underflow[gi])
            );
        end

        // A last pending write retiring this cycle can release a source early.
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            assign busy_o[gi]   = (cnt_q[gi] != '0);
            assign busy_eff[gi] = busy_o[gi] &
                                  ~(WB_BYPASS && (cnt_q[gi] == CNT_W'(1)) && wb_hit[gi]);
        end
    endgenerate

    assign raw  = (iss_rs_en_i[0] & busy_eff[iss_rs_a_i]) |
                  (iss_rs_en_i[1] & busy_eff[iss_rs_b_i]);
    assign full = iss_rd_en_i & (iss_rd_i != '0) & (cnt_q[iss_rd_i] == CNT_MAX);

    assign iss_ready_o = ~flush_i & ~raw & ~full;
    assign fire        = iss_valid_i & iss_ready_o;
    assign inc_vec     = {NREG{fire & iss_rd_en_i}} & reg_onehot(iss_rd_i) & ~NREG'(1);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            stall_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (iss_valid_i && !iss_ready_o && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            // Writebacks in a flush cycle are discarded, so they cannot raise an error.
            if (!flush_i && ((|underflow) || wb_dup)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
    assign err_o       = err_reg;

endmodule
